// File: rtl/dff_bank_rr_arbiter.sv
// dff_bank_rr_arbiter: round-robin arbiter owning a shared WIDTH-bit register, bounded tenures with a release cycle
// Optional grant_count output enabled by DFF_ARB_GRANT_COUNT_EN.
module dff_bank_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wr_data,
  output logic [N_REQ-1:0]       grant,
  output logic [2:0]             owner,
  output logic                   busy,
  output logic [WIDTH-1:0]       q,
  output logic                   q_wr
`ifdef DFF_ARB_GRANT_COUNT_EN
  ,
  output logic [15:0]            grant_count
`endif
);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  state_t state, state_nx;
  logic [2:0] rr_ptr, win, hi, lo;
  logic [3:0] hold_cnt;
  logic found, hfound, own_req;
  logic [WIDTH-1:0] own_data;
  assign busy = state == GRANT;
  // Lowest requester at or above rr_ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi = '0;
    lo = '0;
    hfound = 1'b0;
    found = 1'b0;
    own_req = 1'b0;
    own_data = '0;
    grant = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i] && 3'(i) >= rr_ptr) begin
        hi = 3'(i);
        hfound = 1'b1;
      end
      if (req[i]) begin
        lo = 3'(i);
        found = 1'b1;
      end
      if (owner == 3'(i)) begin
        own_req = req[i];
        own_data = wr_data[i*WIDTH +: WIDTH];
      end
      grant[i] = busy && owner == 3'(i);
    end
    win = hfound ? hi : lo;
    state_nx = state == IDLE ? (found ? GRANT : IDLE) :
               state == GRANT ? ((!own_req || hold_cnt == 4'(HOLD_MAX)) ? RELEASE : GRANT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      hold_cnt <= '0;
      owner <= '0;
      q <= '0;
      q_wr <= 1'b0;
    end else begin
      state <= state_nx;
      q_wr <= busy && own_req;
      if (busy && own_req) q <= own_data;
      if (state == IDLE && found) begin
        owner <= win;
        hold_cnt <= 4'd1;
      end
      if (busy && state_nx == GRANT) hold_cnt <= hold_cnt + 4'd1;
      if (state == RELEASE) rr_ptr <= owner == 3'(N_REQ - 1) ? 3'd0 : owner + 3'd1;
    end
  end
`ifdef DFF_ARB_GRANT_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst_n) grant_count <= '0;
    else if (state == IDLE && found && grant_count != 16'hFFFF) grant_count <= grant_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_dff_bank_rr_arbiter.sv
// tb_dff_bank_rr_arbiter: directed and random checks of dff_bank_rr_arbiter against a tenure-level model
module tb_dff_bank_rr_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int H = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] wr_data = '0;
  logic [N-1:0] grant;
  logic [2:0] owner;
  logic busy, q_wr;
  logic [W-1:0] q;
`ifdef DFF_ARB_GRANT_COUNT_EN
  logic [15:0] grant_count;
`endif
  int n_cmp = 0;
  int n_err = 0;
  int m_owner, m_len, m_last, m_ptr;
  bit m_rel;
  logic [W-1:0] m_q;
  logic m_qwr;

  dff_bank_rr_arbiter #(.N_REQ(N), .WIDTH(W), .HOLD_MAX(H)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr_data(wr_data), .grant(grant),
    .owner(owner), .busy(busy), .q(q), .q_wr(q_wr)
`ifdef DFF_ARB_GRANT_COUNT_EN
    , .grant_count(grant_count)
`endif
  );

  always #5 clk = ~clk;

  // One clock: apply inputs, advance the tenure model across the edge, settle.
  task automatic cyc(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] wd);
    rst_n = r;
    req = rq;
    wr_data = wd;
    @(posedge clk);
    if (r) begin
      m_owner = -1; m_rel = 0; m_ptr = 0; m_len = 0; m_q = '0; m_qwr = 0;
    end else begin
      m_qwr = 0;
      if (m_owner >= 0) begin
        if (rq[m_owner]) begin m_q = wd[m_owner*W +: W]; m_qwr = 1; end
        if (!rq[m_owner] || m_len == H) begin m_rel = 1; m_last = m_owner; m_owner = -1; end
        else m_len++;
      end else if (m_rel) begin
        m_rel = 0;
        m_ptr = (m_last + 1) % N;
      end else begin
        for (int k = 0; k < N; k++)
          if (m_owner < 0 && rq[(m_ptr + k) % N]) begin m_owner = (m_ptr + k) % N; m_len = 1; end
      end
    end
    #1;
  endtask

  function automatic logic [N+W+4:0] exp_vec();
    logic [N-1:0] g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return {g, m_owner >= 0, m_q, m_qwr, m_owner >= 0 ? 3'(m_owner) : 3'd0};
  endfunction

  function automatic logic [N+W+4:0] act_vec();
    return {grant, busy, q, q_wr, busy ? owner : 3'd0};
  endfunction

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      cyc(1, 4'b1111, 32'hFFFF_FFFF);
      n_cmp++;
      if ({grant, busy, q, q_wr} !== 14'h0) begin
        n_err++; $display("FAIL reset c%0d got %h exp 0", c, {grant, busy, q, q_wr});
      end
    end
  endtask

  task automatic test_single();
    logic [N-1:0] eg;
    for (int c = 1; c <= 12; c++) begin
      cyc(0, 4'b0100, 32'h00A5_0000);
      eg = ((c >= 1 && c <= 4) || (c >= 7 && c <= 10)) ? 4'b0100 : 4'b0000;
      n_cmp++;
      if (grant !== eg) begin n_err++; $display("FAIL single_grant c%0d got %b exp %b", c, grant, eg); end
      n_cmp++;
      if (act_vec() !== exp_vec()) begin n_err++; $display("FAIL single_model c%0d got %h exp %h", c, act_vec(), exp_vec()); end
    end
    n_cmp++;
    if (q !== 8'hA5) begin n_err++; $display("FAIL single_q got %h exp a5", q); end
  endtask

  task automatic test_round_robin();
    int seq[$];
    logic prev = 0;
    cyc(1, '0, '0);
    for (int c = 0; c < 28; c++) begin
      cyc(0, 4'b1111, {$urandom});
      if (busy && !prev) seq.push_back(int'(owner));
      prev = busy;
      n_cmp++;
      if (act_vec() !== exp_vec()) begin n_err++; $display("FAIL rr_model c%0d got %h exp %h", c, act_vec(), exp_vec()); end
    end
    n_cmp++;
    if (seq.size() != 5) begin n_err++; $display("FAIL rr_count got %0d exp 5", seq.size()); end
    for (int i = 0; i < seq.size() && i < 5; i++) begin
      n_cmp++;
      if (seq[i] != i % N) begin n_err++; $display("FAIL rr_owner%0d got %0d exp %0d", i, seq[i], i % N); end
    end
  endtask

  task automatic test_early_drop();
    logic [N-1:0] rqs[6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0101, 4'b0101, 4'b0101};
    int writes = 0;
    cyc(1, '0, '0);
    for (int c = 0; c < 6; c++) begin
      cyc(0, rqs[c], {$urandom});
      if (c < 5 && q_wr) writes++;
      n_cmp++;
      if (act_vec() !== exp_vec()) begin n_err++; $display("FAIL drop_model c%0d got %h exp %h", c, act_vec(), exp_vec()); end
    end
    n_cmp++;
    if (writes != 2) begin n_err++; $display("FAIL drop_writes got %0d exp 2", writes); end
    n_cmp++;
    if (!busy || owner !== 3'd2) begin n_err++; $display("FAIL drop_next got busy=%b owner=%0d exp busy=1 owner=2", busy, owner); end
  endtask

  task automatic test_reset_mid();
    cyc(1, '0, '0);
    for (int c = 0; c < 9; c++) cyc(0, 4'b1111, {$urandom});
    n_cmp++;
    if (!busy || owner !== 3'd1) begin n_err++; $display("FAIL mid_pre got busy=%b owner=%0d exp busy=1 owner=1", busy, owner); end
    cyc(1, 4'b1111, {$urandom});
    n_cmp++;
    if (grant !== '0 || q !== '0 || busy !== 1'b0) begin
      n_err++; $display("FAIL mid_rst got grant=%b q=%h busy=%b exp 0", grant, q, busy);
    end
    cyc(0, 4'b1111, {$urandom});
    n_cmp++;
    if (grant !== 4'b0001 || owner !== 3'd0) begin n_err++; $display("FAIL mid_restart got grant=%b owner=%0d exp 0001/0", grant, owner); end
  endtask

  task automatic test_random();
    logic [N-1:0] rq = '0;
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 3) == 0) rq = N'($urandom_range(0, 15));
      cyc($urandom_range(0, 59) == 0, rq, {$urandom});
      n_cmp++;
      if (act_vec() !== exp_vec()) begin n_err++; $display("FAIL rand_model c%0d got %h exp %h", c, act_vec(), exp_vec()); end
      n_cmp++;
      if ($countones(grant) > 1) begin n_err++; $display("FAIL rand_onehot c%0d got %b exp at most one bit", c, grant); end
    end
  endtask

`ifdef DFF_ARB_GRANT_COUNT_EN
  task automatic test_counter();
    cyc(1, '0, '0);
    for (int c = 0; c < 18; c++) cyc(0, 4'b0001, {$urandom});
    n_cmp++;
    if (grant_count !== 16'd3) begin n_err++; $display("FAIL cnt_three got %0d exp 3", grant_count); end
    force dut.grant_count = 16'hFFFF;
    #1;
    release dut.grant_count;
    for (int c = 0; c < 6; c++) cyc(0, 4'b0001, {$urandom});
    n_cmp++;
    if (grant_count !== 16'hFFFF) begin n_err++; $display("FAIL cnt_sat got %h exp ffff", grant_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_early_drop();
    test_reset_mid();
    test_random();
`ifdef DFF_ARB_GRANT_COUNT_EN
    test_counter();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
